// File: rtl/memory_read_arbiter_pkg.sv
// Shared AXI constants, datapath typedefs and helpers for the memory read arbiter.
package MemoryReadArbiterTypes;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned REQUESTER_INDEX_WIDTH = 3;

  typedef logic [REQUESTER_INDEX_WIDTH-1:0] RequesterIndexPath;
  typedef logic [2:0]                       OutstandingCountPath;

  // AXI ARSIZE encoding for a full-width beat.
  function automatic logic [2:0] ArSizeOf(input int unsigned dataWidth);
    return 3'($clog2(dataWidth / 8));
  endfunction

endpackage

// File: rtl/memory_read_arbiter_round_robin_picker.sv
// Combinational round-robin picker: first eligible index at or after the pointer, wrapping.
module round_robin_picker #(
  parameter int unsigned N        = 4,
  parameter int unsigned IdxWidth = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        eligible,
  input  logic [IdxWidth-1:0] pointer,
  output logic [N-1:0]        grant,
  output logic [IdxWidth-1:0] grantIdx,
  output logic                grantValid
);

  // Scan N candidates starting at the pointer; the first hit wins.
  always_comb begin
    logic [IdxWidth-1:0] idx;
    grant      = '0;
    grantIdx   = '0;
    grantValid = 1'b0;
    idx        = '0;
    for (int k = 0; k < int'(N); k++) begin
      idx = IdxWidth'((int'(pointer) + k) % int'(N));
      if (!grantValid && eligible[idx]) begin
        grantValid  = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

endmodule

// File: rtl/memory_read_arbiter.sv
// Round-robin arbiter sharing the AXI4 AR/R channels between internal read requesters.
// Each grant issues one fixed-length INCR burst tagged with ARID = requester index.
module memory_read_arbiter
  import MemoryReadArbiterTypes::*;
#(
  parameter int unsigned REQUESTER_NUM   = 4,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ID_WIDTH        = 3,
  parameter int unsigned BURST_LEN       = 8,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [REQUESTER_NUM-1:0]          reqValid,
  input  logic [REQUESTER_NUM*ADDR_WIDTH-1:0] reqAddr,
  output logic [REQUESTER_NUM-1:0]          reqReady,
  output logic [REQUESTER_NUM-1:0]          respValid,
  output logic [DATA_WIDTH-1:0]             respData,
  output logic                              respLast,
  output logic                              errFlag,
  output logic [ID_WIDTH-1:0]               arId,
  output logic [ADDR_WIDTH-1:0]             arAddr,
  output logic [7:0]                        arLen,
  output logic [2:0]                        arSize,
  output logic [1:0]                        arBurst,
  output logic                              arValid,
  input  logic                              arReady,
  input  logic [ID_WIDTH-1:0]               rId,
  input  logic [DATA_WIDTH-1:0]             rData,
  input  logic [1:0]                        rResp,
  input  logic                              rLast,
  input  logic                              rValid,
  output logic                              rReady
);

  localparam int unsigned IdxWidth   = (REQUESTER_NUM > 1) ? $clog2(REQUESTER_NUM) : 1;
  localparam int unsigned OffsetBits = $clog2(BURST_LEN * DATA_WIDTH / 8);

  logic                      arValidQ;
  logic [ID_WIDTH-1:0]       arIdQ;
  logic [ADDR_WIDTH-1:0]     arAddrQ;
  logic [IdxWidth-1:0]       rrPtrQ, rrPtrD;
  OutstandingCountPath       outstandingQ [REQUESTER_NUM];
  OutstandingCountPath       outstandingD [REQUESTER_NUM];
  logic [REQUESTER_NUM-1:0]  respValidQ, respValidD;
  logic [DATA_WIDTH-1:0]     respDataQ;
  logic                      respLastQ;
  logic                      errFlagQ;

  logic [ADDR_WIDTH-1:0]     reqAddrArr [REQUESTER_NUM];
  logic [REQUESTER_NUM-1:0]  eligible, grant;
  logic [IdxWidth-1:0]       grantIdx;
  logic                      grantValid, loadOk, grantFire, idInRange;
  logic [ADDR_WIDTH-1:0]     alignedAddr;

  for (genvar g = 0; g < int'(REQUESTER_NUM); g++) begin : gen_req
    assign reqAddrArr[g] = reqAddr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign eligible[g]   = reqValid[g] &&
                           (outstandingQ[g] < OutstandingCountPath'(MAX_OUTSTANDING));
  end

  // The AR register can take a new burst when empty or being handed off this cycle.
  assign loadOk    = !arValidQ || arReady;
  assign grantFire = grantValid && loadOk && !rst;
  assign reqReady  = grantFire ? grant : '0;
  assign idInRange = (32'(rId) < REQUESTER_NUM);

  round_robin_picker #(
    .N        (REQUESTER_NUM),
    .IdxWidth (IdxWidth)
  ) u_picker (
    .eligible   (eligible),
    .pointer    (rrPtrQ),
    .grant      (grant),
    .grantIdx   (grantIdx),
    .grantValid (grantValid)
  );

  // Burst-align the granted address and advance the round-robin pointer past the winner.
  always_comb begin
    alignedAddr                 = reqAddrArr[grantIdx];
    alignedAddr[OffsetBits-1:0] = '0;
    rrPtrD = rrPtrQ;
    if (grantFire) begin
      rrPtrD = (grantIdx == IdxWidth'(REQUESTER_NUM - 1)) ? '0 : grantIdx + IdxWidth'(1);
    end
  end

  // Per-requester outstanding bursts: +1 on grant, -1 on own rLast, saturating at 0.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    for (int i = 0; i < int'(REQUESTER_NUM); i++) begin
      inc = grantFire && (grantIdx == IdxWidth'(i));
      dec = rValid && rLast && (rId == ID_WIDTH'(i));
      outstandingD[i] = outstandingQ[i];
      if (inc && !dec) begin
        outstandingD[i] = outstandingQ[i] + 3'd1;
      end else if (dec && !inc && (outstandingQ[i] != '0)) begin
        outstandingD[i] = outstandingQ[i] - 3'd1;
      end
    end
  end

  // One-hot routing of the incoming beat by RID; out-of-range IDs route nowhere.
  always_comb begin
    respValidD = '0;
    for (int i = 0; i < int'(REQUESTER_NUM); i++) begin
      respValidD[i] = rValid && (rId == ID_WIDTH'(i));
    end
  end

  // AR holding register; fields only change on a load so they stay stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      arValidQ <= 1'b0;
    end else if (loadOk) begin
      arValidQ <= grantFire;
      if (grantFire) begin
        arIdQ   <= ID_WIDTH'(grantIdx);
        arAddrQ <= alignedAddr;
      end
    end
  end

  // Round-robin pointer and outstanding counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtrQ <= '0;
      for (int i = 0; i < int'(REQUESTER_NUM); i++) outstandingQ[i] <= '0;
    end else begin
      rrPtrQ <= rrPtrD;
      for (int i = 0; i < int'(REQUESTER_NUM); i++) outstandingQ[i] <= outstandingD[i];
    end
  end

  // Registered R return path and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      respValidQ <= '0;
      respLastQ  <= 1'b0;
      errFlagQ   <= 1'b0;
    end else begin
      respValidQ <= respValidD;
      respLastQ  <= rValid && rLast && idInRange;
      if (rValid) respDataQ <= rData;
      if (rValid && ((rResp != AXI_RESP_OKAY) || !idInRange)) errFlagQ <= 1'b1;
    end
  end

  assign arValid   = arValidQ;
  assign arId      = arIdQ;
  assign arAddr    = arAddrQ;
  assign arLen     = 8'(BURST_LEN - 1);
  assign arSize    = ArSizeOf(DATA_WIDTH);
  assign arBurst   = AXI_BURST_INCR;
  assign respValid = respValidQ;
  assign respData  = respDataQ;
  assign respLast  = respLastQ;
  assign errFlag   = errFlagQ;
  assign rReady    = 1'b1;

endmodule

// File: tb/tb_memory_read_arbiter.sv
// Scoreboard bench for memory_read_arbiter with a behavioural arbitration/routing model.
module tb_memory_read_arbiter;

  localparam int NREQ = 4;
  localparam int MAXO = 2;
  localparam int BLEN = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NREQ-1:0]  reqValid = '0;
  logic [NREQ*32-1:0] reqAddr = '0;
  logic [NREQ-1:0]  reqReady, respValid;
  logic [63:0]      respData;
  logic             respLast, errFlag;
  logic [2:0]       arId;
  logic [31:0]      arAddr;
  logic [7:0]       arLen;
  logic [2:0]       arSize;
  logic [1:0]       arBurst;
  logic             arValid;
  logic             arReady = 1'b0;
  logic [2:0]       rId = '0;
  logic [63:0]      rData = '0;
  logic [1:0]       rResp = '0;
  logic             rLast = 1'b0;
  logic             rValid = 1'b0;
  logic             rReady;

  memory_read_arbiter dut (
    .clk(clk), .rst(rst), .reqValid(reqValid), .reqAddr(reqAddr), .reqReady(reqReady),
    .respValid(respValid), .respData(respData), .respLast(respLast), .errFlag(errFlag),
    .arId(arId), .arAddr(arAddr), .arLen(arLen), .arSize(arSize), .arBurst(arBurst),
    .arValid(arValid), .arReady(arReady), .rId(rId), .rData(rData), .rResp(rResp),
    .rLast(rLast), .rValid(rValid), .rReady(rReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] oh;
    logic [63:0]     data;
    logic            last;
  } RespExp;

  int nChecks = 0;
  int nErrors = 0;
  bit active = 0;

  RespExp respQ[$];
  int     burstQ[$];
  int     grantLog[$];
  logic [31:0] hsAddrLog[$];
  int     owe [NREQ];
  int     beatIdx [NREQ];
  int     rRate = 0;
  int     errRate = 0;
  int     lastGrant = -1;
  int     respBeatCnt = 0;
  int     respLastCnt = 0;

  // Reference model state
  int          mOut [NREQ];
  int          mPtr = 0;
  bit          mArPend = 0;
  int          mArId = 0;
  logic [31:0] mArAddr = '0;
  bit          mErr = 0;
  bit          expRespNext = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT against model, pop response scoreboard, then advance the model.
  always @(negedge clk) begin
    int g;
    int idx;
    bit inc, dec;
    RespExp e;
    if (active) begin
      check("respPresent", 64'(|respValid), 64'(expRespNext));
      if (|respValid) begin
        if (respQ.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL respUnexpected: got respValid=%b expected no beat", respValid);
        end else begin
          e = respQ.pop_front();
          check("respValid", 64'(respValid), 64'(e.oh));
          check("respData", respData, e.data);
          check("respLast", 64'(respLast), 64'(e.last));
        end
        if (respValid[0]) respBeatCnt++;
        if (respValid[0] && respLast) respLastCnt++;
      end else begin
        check("respLastIdle", 64'(respLast), 64'd0);
      end
      check("errFlag", 64'(errFlag), 64'(mErr));
      check("arValid", 64'(arValid), 64'(mArPend));
      if (mArPend) begin
        check("arId", 64'(arId), 64'(mArId));
        check("arAddr", 64'(arAddr), 64'(mArAddr));
        check("arLen", 64'(arLen), 64'(BLEN - 1));
        check("arSize", 64'(arSize), 64'd3);
        check("arBurst", 64'(arBurst), 64'd1);
      end
      g = -1;
      if (!rst && (!mArPend || arReady)) begin
        for (int k = 0; k < NREQ; k++) begin
          idx = (mPtr + k) % NREQ;
          if (g < 0 && reqValid[idx] && mOut[idx] < MAXO) g = idx;
        end
      end
      check("reqReady", 64'(reqReady), (g >= 0) ? (64'd1 << g) : 64'd0);
      lastGrant = g;
      if (rst) begin
        for (int i = 0; i < NREQ; i++) mOut[i] = 0;
        mPtr = 0; mArPend = 0; mErr = 0; expRespNext = 0;
      end else begin
        if (mArPend && arReady) begin
          burstQ.push_back(mArId);
          hsAddrLog.push_back(arAddr);
        end
        if (!mArPend || arReady) begin
          mArPend = (g >= 0);
          if (g >= 0) begin
            mArId   = g;
            mArAddr = reqAddr[g*32 +: 32] & ~32'h3F;
          end
        end
        for (int i = 0; i < NREQ; i++) begin
          inc = (g == i);
          dec = rValid && rLast && (int'(rId) == i);
          if (inc && !dec) mOut[i]++;
          else if (dec && !inc && mOut[i] > 0) mOut[i]--;
        end
        if (g >= 0) begin
          mPtr = (g + 1) % NREQ;
          grantLog.push_back(g);
        end
        if (rValid && (rResp != 2'b00 || int'(rId) >= NREQ)) mErr = 1;
        expRespNext = rValid && (int'(rId) < NREQ);
      end
    end
  end

  // One cycle of stimulus: slave model returns beats of accepted bursts, randomly interleaved.
  task automatic tick();
    int cand[$];
    int id;
    RespExp e;
    @(posedge clk);
    #1;
    while (burstQ.size() > 0) begin
      id = burstQ.pop_front();
      owe[id]++;
    end
    rValid = 1'b0; rLast = 1'b0; rResp = 2'b00; rId = '0;
    rData = {$urandom, $urandom};
    for (int i = 0; i < NREQ; i++) if (owe[i] > 0) cand.push_back(i);
    if (!rst && cand.size() > 0 && int'($urandom_range(99)) < rRate) begin
      id = cand[$urandom_range(cand.size() - 1)];
      rValid = 1'b1;
      rId = 3'(id);
      beatIdx[id]++;
      if (beatIdx[id] == BLEN) begin
        rLast = 1'b1;
        beatIdx[id] = 0;
        owe[id]--;
      end
      rResp = (int'($urandom_range(99)) < errRate) ? 2'b10 : 2'b00;
      e.oh = NREQ'(1 << id); e.data = rData; e.last = rLast;
      respQ.push_back(e);
    end
  endtask

  task automatic sendBeat(input int id, input logic [1:0] resp, input logic last);
    RespExp e;
    rRate = 0;
    tick();
    rValid = 1'b1; rId = 3'(id); rResp = resp; rLast = last;
    if (id < NREQ) begin
      e.oh = NREQ'(1 << id); e.data = rData; e.last = last;
      respQ.push_back(e);
    end
  endtask

  task automatic doReset();
    rRate = 0; arReady = 1'b0; reqValid = '0;
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic bit busy();
    bit b = mArPend || (burstQ.size() > 0);
    for (int i = 0; i < NREQ; i++) if (owe[i] > 0) b = 1;
    return b;
  endfunction

  task automatic drain();
    int n = 0;
    reqValid = '0; rRate = 100; arReady = 1'b1; errRate = 0;
    do begin
      tick();
      n++;
    end while (busy() && n < 600);
    nChecks++;
    if (busy()) begin
      nErrors++;
      $display("FAIL drainTimeout: still busy after %0d cycles, required idle", n);
    end
    tick();
    tick();
  endtask

  // Keep requesting each masked requester until it has been granted once.
  task automatic request(input logic [NREQ-1:0] mask);
    int n = 0;
    reqValid = mask;
    while (reqValid != '0 && n < 30) begin
      tick();
      if (lastGrant >= 0) reqValid[lastGrant] = 1'b0;
      n++;
    end
    nChecks++;
    if (reqValid != '0) begin
      nErrors++;
      $display("FAIL requestTimeout: pending %b, required all granted", reqValid);
    end
    reqValid = '0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin owe[i] = 0; beatIdx[i] = 0; mOut[i] = 0; end
    @(posedge clk);
    #1;
    active = 1;
    tick();
    tick();
    check("rstArValid", 64'(arValid), 64'd0);
    check("rstReqReady", 64'(reqReady), 64'd0);
    check("rstRespValid", 64'(respValid), 64'd0);
    check("rstErrFlag", 64'(errFlag), 64'd0);
    check("rReady", 64'(rReady), 64'd1);
    rst = 1'b0;

    // Single request from requester 0
    reqAddr[31:0] = 32'h1000_0013;
    arReady = 1'b1;
    respBeatCnt = 0; respLastCnt = 0;
    request(4'b0001);
    rRate = 100;
    repeat (14) tick();
    check("singleArAddr", 64'(hsAddrLog[0]), 64'h1000_0000);
    check("singleBeats", 64'(respBeatCnt), 64'd8);
    check("singleLast", 64'(respLastCnt), 64'd1);
    drain();

    // All requesters continuously: fills every counter, then resumes on returns
    doReset();
    grantLog.delete();
    for (int i = 0; i < NREQ; i++) reqAddr[i*32 +: 32] = $urandom;
    reqValid = 4'hF; arReady = 1'b1; rRate = 0;
    repeat (14) tick();
    check("fullGrantCount", 64'(grantLog.size()), 64'd8);
    for (int i = 0; i < 8 && i < grantLog.size(); i++) check("fullGrantOrder", 64'(grantLog[i]), 64'(i % 4));
    rRate = 100;
    repeat (40) tick();
    nChecks++;
    if (grantLog.size() <= 8) begin
      nErrors++;
      $display("FAIL resumeGrants: got %0d grants, required more than 8", grantLog.size());
    end
    drain();

    // AR stall: fields must hold and no new grant while arReady is low
    reqValid = 4'hF; arReady = 1'b0; rRate = 0;
    repeat (6) tick();
    arReady = 1'b1;
    repeat (3) tick();
    drain();

    // Interleaved bursts for ids 1 and 2
    arReady = 1'b1; rRate = 0;
    request(4'b0110);
    rRate = 100;
    repeat (20) tick();
    drain();
    check("noErrYet", 64'(errFlag), 64'd0);

    // Sticky error flag
    sendBeat(0, 2'b10, 1'b0);
    tick();
    check("errSet", 64'(errFlag), 64'd1);
    sendBeat(1, 2'b00, 1'b0);
    sendBeat(2, 2'b00, 1'b0);
    tick();
    check("errSticky", 64'(errFlag), 64'd1);
    doReset();
    check("errCleared", 64'(errFlag), 64'd0);
    sendBeat(5, 2'b00, 1'b1);
    tick();
    check("badIdErr", 64'(errFlag), 64'd1);

    // Reset with bursts outstanding and AR pending
    doReset();
    reqValid = 4'b0011; arReady = 1'b1; rRate = 0;
    repeat (3) tick();
    arReady = 1'b0;
    tick();
    doReset();
    check("rstMidArValid", 64'(arValid), 64'd0);
    grantLog.delete();
    reqValid = 4'b1001; arReady = 1'b1;
    tick();
    tick();
    reqValid = '0;
    check("postRstGrantSeen", 64'(grantLog.size() > 0), 64'd1);
    if (grantLog.size() > 0) check("postRstFirstGrant", 64'(grantLog[0]), 64'd0);
    drain();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rRate = 50; errRate = 2;
      tick();
      reqValid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) reqAddr[i*32 +: 32] = $urandom;
      arReady = ($urandom_range(3) != 0);
    end
    drain();
    check("respQueueEmpty", 64'(respQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
